// File: rtl/pll_pkg.sv
// pll_pkg: shared types and default constants for the PLL loop blocks
package pll_pkg;
  typedef enum logic [1:0] {IDLE, LEAD_REF, LEAD_FB} pfd_state_t;
  localparam int ERR_WIDTH_DEF = 16;
  localparam int LOCK_TOL_DEF = 2;
  localparam int LOCK_COUNT_DEF = 8;
endpackage

// File: rtl/edge_synchronizer.sv
// edge_synchronizer: multi-flop synchronizer with a one-cycle rising-edge pulse
module edge_synchronizer #(
  parameter int SYNC_STAGES = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      last <= sync[SYNC_STAGES-1];
    end
  assign rise = sync[SYNC_STAGES-1] & ~last;
endmodule

// File: rtl/digital_pfd.sv
// digital_pfd: phase-frequency detector measuring ref/fb rising-edge offset in clk cycles
module digital_pfd
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_WIDTH   = ERR_WIDTH_DEF,
  parameter int LOCK_TOL    = LOCK_TOL_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        ref_clk_digital,
  input  logic                        fb_clk_digital,
  output logic                        up,
  output logic                        down,
  output logic signed [ERR_WIDTH-1:0] phase_err,
  output logic                        phase_err_valid,
  output logic                        locked
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [ERR_WIDTH-1:0] CNT_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] TOL = ERR_WIDTH'(LOCK_TOL);
  pfd_state_t state, state_nxt;
  logic [ERR_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic signed [ERR_WIDTH-1:0] err_nxt;
  logic [GW-1:0] good, good_nxt;
  logic valid_nxt, in_tol, ref_rise, fb_rise;
  edge_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ref (
    .clk(clk), .reset(reset), .async_in(ref_clk_digital), .rise(ref_rise)
  );
  edge_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_fb (
    .clk(clk), .reset(reset), .async_in(fb_clk_digital), .rise(fb_rise)
  );
  assign cnt_inc = cnt == CNT_MAX ? cnt : cnt + ERR_WIDTH'(1);
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt_inc;
    err_nxt = phase_err;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = ref_rise ^ fb_rise ? ERR_WIDTH'(1) : '0;
        state_nxt = ref_rise && !fb_rise ? LEAD_REF : fb_rise && !ref_rise ? LEAD_FB : IDLE;
        valid_nxt = ref_rise && fb_rise;
        err_nxt = ref_rise && fb_rise ? '0 : phase_err;
      end
      LEAD_REF: if (fb_rise) begin
        valid_nxt = 1'b1;
        err_nxt = $signed(cnt);
        cnt_nxt = ref_rise ? ERR_WIDTH'(1) : '0;
        state_nxt = ref_rise ? LEAD_REF : IDLE;
      end
      LEAD_FB: if (ref_rise) begin
        valid_nxt = 1'b1;
        err_nxt = -$signed(cnt);
        cnt_nxt = fb_rise ? ERR_WIDTH'(1) : '0;
        state_nxt = fb_rise ? LEAD_FB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
      valid_nxt = 1'b0;
      err_nxt = phase_err;
    end
  end
  assign in_tol = (err_nxt <= TOL) && (err_nxt >= -TOL);
  assign good_nxt = !enable ? '0 : !valid_nxt ? good : !in_tol ? '0 :
                    good == GOOD_MAX ? good : good + GW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      phase_err <= '0;
      phase_err_valid <= 1'b0;
      good <= '0;
      locked <= 1'b0;
      up <= 1'b0;
      down <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      phase_err <= err_nxt;
      phase_err_valid <= valid_nxt;
      good <= good_nxt;
      locked <= enable && good == GOOD_MAX;
      up <= state_nxt == LEAD_REF;
      down <= state_nxt == LEAD_FB;
    end
endmodule

// File: tb/tb_digital_pfd.sv
// tb_digital_pfd: directed self-checking bench for digital_pfd
module tb_digital_pfd;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, ref_in = 1'b0, fb_in = 1'b0;
  logic up, down, phase_err_valid, locked;
  logic signed [15:0] phase_err;
  int errors = 0, checks = 0;
  int cyc = 0, n_up = 0, n_down = 0, n_valid = 0, n_both = 0, n_up_fall = 0;
  int last_err = 0, v_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic up_prev = 1'b0, lk_prev = 1'b0;
  int u0, d0, v0, f0;

  digital_pfd dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ref_clk_digital(ref_in), .fb_clk_digital(fb_in),
    .up(up), .down(down), .phase_err(phase_err),
    .phase_err_valid(phase_err_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    n_up += int'(up);
    n_down += int'(down);
    if (up && down) n_both++;
    if (up_prev && !up) n_up_fall++;
    if (phase_err_valid) begin
      n_valid++;
      last_err = int'(phase_err);
      v_cyc = cyc;
    end
    if (locked && !lk_prev) rise_cyc = cyc;
    if (!locked && lk_prev) fall_cyc = cyc;
    up_prev = up;
    lk_prev = locked;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    u0 = n_up; d0 = n_down; v0 = n_valid; f0 = n_up_fall;
  endtask

  // ref rises before edge ra, fb before edge fa (counted from now)
  task automatic cmp(input int ra, input int fa);
    int n;
    n = (ra > fa ? ra : fa) + 6;
    for (int i = 0; i < n; i++) begin
      if (i == ra) ref_in = 1'b1;
      if (i == fa) fb_in = 1'b1;
      tick;
    end
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (4) tick;
  endtask

  initial begin
    #2 ref_in = 1'b1;
    #7 fb_in = 1'b1;
    check("reset_outs_a", int'({up, down, phase_err_valid, locked}), 0);
    #13 ref_in = 1'b0;
    #9 fb_in = 1'b0;
    check("reset_outs_b", int'({up, down, phase_err_valid, locked}), 0);
    check("reset_err", int'(phase_err), 0);
    repeat (3) tick;
    @(negedge clk) reset = 1'b0;
    repeat (3) tick;

    // ref leads by 10, with start latency check
    snap;
    ref_in = 1'b1;
    tick;
    tick;
    check("lat_up_low", int'(up), 0);
    tick;
    check("lat_up_high", int'(up), 1);
    repeat (7) tick;
    fb_in = 1'b1;
    repeat (8) tick;
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (4) tick;
    check("ref_up_cycles", n_up - u0, 10);
    check("ref_down_cycles", n_down - d0, 0);
    check("ref_strobes", n_valid - v0, 1);
    check("ref_err", last_err, 10);

    snap;
    cmp(5, 0);
    check("fb_down_cycles", n_down - d0, 5);
    check("fb_up_cycles", n_up - u0, 0);
    check("fb_err", last_err, -5);

    snap;
    cmp(0, 0);
    check("sim_strobes", n_valid - v0, 1);
    check("sim_err", last_err, 0);
    check("sim_updown", (n_up - u0) + (n_down - d0), 0);

    // lock acquisition and loss
    cmp(0, 7);
    cmp(0, 1); cmp(2, 0); cmp(0, 0); cmp(0, 2); cmp(0, 1); cmp(1, 0); cmp(0, 0);
    check("lock_after7", int'(locked), 0);
    cmp(2, 0);
    check("lock_after8", int'(locked), 1);
    check("lock_rise_delay", rise_cyc - v_cyc, 1);
    cmp(0, 7);
    check("unlock_err", last_err, 7);
    check("unlock", int'(locked), 0);
    check("unlock_delay", fall_cyc - v_cyc, 1);

    // cycle slip: two ref rises 20 apart, fb 5 after the second
    snap;
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 20) ref_in = 1'b1;
      if (i == 5) ref_in = 1'b0;
      if (i == 25) fb_in = 1'b1;
      tick;
    end
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (4) tick;
    check("slip_err", last_err, 25);
    check("slip_up_cycles", n_up - u0, 25);
    check("slip_up_falls", n_up_fall - f0, 1);

    cmp(0, 40000);
    check("sat_err", last_err, 32767);

    // enable dropped mid LEAD_REF
    repeat (8) cmp(0, 1);
    check("relock_a", int'(locked), 1);
    snap;
    ref_in = 1'b1;
    repeat (5) tick;
    check("en_up_before", int'(up), 1);
    enable = 1'b0;
    tick;
    check("en_up_after", int'(up), 0);
    check("en_locked", int'(locked), 0);
    fb_in = 1'b1;
    repeat (6) tick;
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (4) tick;
    enable = 1'b1;
    repeat (6) tick;
    check("en_strobes", n_valid - v0, 0);
    check("en_reenable_quiet", int'({up, down}), 0);

    // async reset mid LEAD_REF
    repeat (8) cmp(0, 1);
    check("relock_b", int'(locked), 1);
    check("relock_err", int'(phase_err), 1);
    snap;
    ref_in = 1'b1;
    repeat (5) tick;
    check("rst_up_before", int'(up), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_outs_now", int'({up, down, phase_err_valid, locked}), 0);
    check("rst_err_now", int'(phase_err), 0);
    for (int i = 0; i < 6; i++) begin
      fb_in = ~fb_in;
      tick;
    end
    check("rst_outs_held", int'({up, down, phase_err_valid, locked}), 0);
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (3) tick;
    @(negedge clk) reset = 1'b0;
    repeat (5) tick;
    check("rst_strobes", n_valid - v0, 0);
    check("never_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
